// File: rtl/vec_writeback.sv
// rtl/vec_writeback.sv - streams a captured PE result vector into scratch memory
//
// Purpose:
//   Sits behind the vector add/subtract PE. An issue pulse in IDLE samples
//   the destination base address. One cycle later the PE's registered result
//   is captured into a local buffer. The buffer is then written word by word
//   to consecutive addresses (modulo 2^addrwidth) over a valid/ready port.
//
// Ports:
//   clk        in   system clock, rising edge
//   RESET      in   asynchronous active-low reset
//   start      in   issue pulse; accepted only in IDLE
//   base_addr  in   word address of element 0, sampled with start
//   vec_in     in   PE result vector, captured at the end of the WAIT cycle
//   busy       out  high from the cycle after start through the done cycle
//   mem_we     out  write valid
//   mem_ready  in   write accepted when mem_we && mem_ready at a rising edge
//   mem_addr   out  write word address
//   mem_wdata  out  write data
//   done       out  single-cycle pulse after the last word is accepted

module vec_writeback #(
    parameter int matsize   = 16,
    parameter int wordsize  = 32,
    parameter int addrwidth = 16
) (
    input  logic                               clk,
    input  logic                               RESET,
    input  logic                               start,
    input  logic [addrwidth-1:0]               base_addr,
    input  logic [matsize-1:0][wordsize-1:0]   vec_in,
    output logic                               busy,
    output logic                               mem_we,
    input  logic                               mem_ready,
    output logic [addrwidth-1:0]               mem_addr,
    output logic [wordsize-1:0]                mem_wdata,
    output logic                               done
);

    localparam int IW = (matsize > 1) ? $clog2(matsize) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(matsize - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [addrwidth-1:0]               base_q, base_d;
    logic [matsize-1:0][wordsize-1:0]   buf_q, buf_d;
    logic [IW-1:0]                      index_q, index_d;
    logic                               busy_q, busy_d;
    logic                               mem_we_q, mem_we_d;
    logic [addrwidth-1:0]               mem_addr_q, mem_addr_d;
    logic [wordsize-1:0]                mem_wdata_q, mem_wdata_d;
    logic                               done_q, done_d;

    logic                               accept;
    logic [IW-1:0]                      next_idx;

    assign accept   = mem_we_q && mem_ready;
    assign next_idx = index_q + IW'(1);

    // State register and all registered outputs
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            buf_q       <= '0;
            index_q     <= '0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            buf_q       <= buf_d;
            index_q     <= index_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_WAIT;
            S_WAIT:   state_d = S_STREAM;
            S_STREAM: if (accept && index_q == LAST_IDX) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; outputs are computed from the next state
    // so that they are registered yet line up with it.
    always_comb begin
        base_d      = base_q;
        buf_d       = buf_q;
        index_d     = index_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = (state_d != S_IDLE);
        mem_we_d    = (state_d == S_STREAM);
        done_d      = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) base_d = base_addr;
            end
            S_WAIT: begin
                // PE result is valid now; element 0 comes straight from the
                // input since the buffer is only written at this same edge.
                buf_d       = vec_in;
                index_d     = '0;
                mem_addr_d  = base_q;
                mem_wdata_d = vec_in[0];
            end
            S_STREAM: begin
                // On a stall nothing changes, so addr/data stay stable.
                if (accept && index_q != LAST_IDX) begin
                    index_d     = next_idx;
                    mem_addr_d  = mem_addr_q + addrwidth'(1);
                    mem_wdata_d = buf_q[next_idx];
                end
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vec_writeback.sv
// tb/tb_vec_writeback.sv - directed self-checking bench for vec_writeback

module tb_vec_writeback;

    logic                clk = 1'b0;
    logic                RESET;
    logic                start;
    logic [15:0]         base_addr;
    logic [15:0][31:0]   vec;
    logic                busy, mem_we, mem_ready, done;
    logic [15:0]         mem_addr;
    logic [31:0]         mem_wdata;

    logic                bp = 1'b0;
    logic                tog = 1'b0;
    logic                rdy_force;
    assign mem_ready = bp ? tog : rdy_force;

    vec_writeback #(.matsize(16), .wordsize(32), .addrwidth(16)) dut (
        .clk(clk), .RESET(RESET), .start(start), .base_addr(base_addr),
        .vec_in(vec), .busy(busy), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          dc[$];
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] st_addr;
    logic [31:0] st_data;

    always @(negedge clk) begin
        if (RESET) begin
            if (prev_stall && (!mem_we || mem_addr != st_addr || mem_wdata != st_data))
                stall_viol <= stall_viol + 1;
            if (mem_we && mem_ready) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                wc.push_back(cyc);
            end
            if (done) dc.push_back(cyc);
            prev_stall <= mem_we && !mem_ready;
            st_addr    <= mem_addr;
            st_data    <= mem_wdata;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [31:0] exp_d[16];
    int          t0;

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
    endtask

    task automatic issue(input logic [15:0] b);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic verify(input string tag, input logic [15:0] base, input bit timed);
        logic [15:0] a;
        check({tag, "_nwrites"}, wa.size(), 16);
        check({tag, "_ndone"}, dc.size(), 1);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            a = base + 16'(i);
            check($sformatf("%s_addr%0d", tag, i), {16'd0, wa[i]}, {16'd0, a});
            check($sformatf("%s_data%0d", tag, i), wd[i], exp_d[i]);
        end
        if (timed && wc.size() == 16 && dc.size() >= 1) begin
            check({tag, "_first_cyc"}, wc[0], t0 + 2);
            check({tag, "_last_cyc"}, wc[15], t0 + 17);
            check({tag, "_done_cyc"}, dc[0], t0 + 18);
        end
    endtask

    initial begin
        RESET = 1'b0; start = 1'b0; base_addr = '0; rdy_force = 1'b1; vec = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b1;

        // 1: basic transfer
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 100); exp_d[i] = 32'(i + 100); end
        clear_log();
        issue(16'h0040);
        @(negedge clk);
        check("basic_busy_t1", busy, 1);
        check("basic_we_t1", mem_we, 0);
        wait_done("basic", 100);
        @(negedge clk);
        check("basic_busy_after", busy, 0);
        repeat (2) @(negedge clk);
        verify("basic", 16'h0040, 1'b1);

        // 2: backpressure on alternate cycles
        for (int i = 0; i < 16; i++) begin vec[i] = 32'hA500_0000 + 32'(i * 3); exp_d[i] = 32'hA500_0000 + 32'(i * 3); end
        clear_log();
        bp = 1'b1;
        issue(16'h1000);
        wait_done("bp", 100);
        repeat (3) @(negedge clk);
        bp = 1'b0;
        verify("bp", 16'h1000, 1'b0);
        check("bp_stall_stable", stall_viol, 0);

        // 3: address wrap
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i * 7 + 1); exp_d[i] = 32'(i * 7 + 1); end
        clear_log();
        issue(16'hFFFE);
        wait_done("wrap", 100);
        repeat (3) @(negedge clk);
        verify("wrap", 16'hFFFE, 1'b1);

        // 4: vec_in changes after the capture edge
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 200); exp_d[i] = 32'(i + 200); end
        clear_log();
        issue(16'h0100);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) vec[i] = 32'hDEAD_BEEF;
        wait_done("cap", 100);
        repeat (3) @(negedge clk);
        verify("cap", 16'h0100, 1'b1);

        // 5: start while busy and in the done cycle is ignored
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 300); exp_d[i] = 32'(i + 300); end
        clear_log();
        issue(16'h0500);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 16'h1234;
        for (int i = 0; i < 16; i++) vec[i] = 32'h5555_0000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int g = 0; g < 40 && cyc < t0 + 18; g++) begin @(posedge clk); #1; end
        start = 1'b1; base_addr = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        verify("busy_start", 16'h0500, 1'b1);
        check("busy_start_idle", busy, 0);
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 400); exp_d[i] = 32'(i + 400); end
        clear_log();
        issue(16'h0200);
        wait_done("restart", 100);
        repeat (3) @(negedge clk);
        verify("restart", 16'h0200, 1'b1);

        // 6: reset during the 5th write
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 500); exp_d[i] = 32'(i + 500); end
        clear_log();
        issue(16'h0300);
        for (int g = 0; g < 40 && cyc < t0 + 6; g++) begin @(posedge clk); #1; end
        check("rst_mid_we_before", mem_we, 1);
        #2 RESET = 1'b0;
        #1;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_nwrites", wa.size(), 4);
        check("rst_mid_ndone", dc.size(), 0);
        check("rst_mid_idle_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin vec[i] = 32'(i + 600); exp_d[i] = 32'(i + 600); end
        clear_log();
        issue(16'h0700);
        wait_done("post_rst", 100);
        repeat (3) @(negedge clk);
        verify("post_rst", 16'h0700, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_writeback.md
Name: vec_writeback

Overview:
- Downstream of the vector add/subtract PE.
- Latches the PE's registered matsize-word result one cycle after an issue pulse.
- Streams the result word-by-word onto the scratch-memory write port with a valid/ready handshake, at consecutive addresses from a base.
- Reports busy, and pulses done when the last word is accepted, so the controller can issue the next vector op.

Parameters:
- matsize, 16, number of words per vector (matches PE vector length).
- wordsize, 32, bits per word.
- addrwidth, 16, memory word-address width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  issue pulse, asserted in the same cycle the PE's a/b/ctrl are presented.
- base_addr  input  addrwidth  destination word address of element 0; sampled with start.
- vec_in  input  matsize x wordsize  PE result vector (packed [matsize-1:0][wordsize-1:0]).
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- mem_we  output  1  write valid.
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready at a rising edge.
- mem_addr  output  addrwidth  write address.
- mem_wdata  output  wordsize  write data.
- done  output  1  single-cycle pulse after the final word is accepted.

Behaviour:
- Reset (RESET low, async): state=IDLE; busy=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0; index=0; result buffer cleared.
  - Reset mid-transfer aborts immediately, with no further writes.
- States: IDLE, WAIT, STREAM, DONE.
- IDLE:
  - start=1 → latch base_addr, go to WAIT.
  - start=0 → stay.
- WAIT (one cycle, covers the PE's 1-cycle register latency):
  - At the closing edge, latch all of vec_in into the internal buffer, set index=0, go to STREAM.
- STREAM:
  - mem_we=1, mem_addr=base+index, mem_wdata=buffer[index].
  - mem_ready=1 at an edge → index+1.
  - mem_ready=1 with index==matsize-1 → go to DONE, mem_we drops.
  - mem_ready=0 → addr, data and mem_we held stable (no retraction while valid).
- DONE (one cycle): done=1, busy=1; next state IDLE.
  - start in the DONE cycle is ignored; start is accepted only in IDLE.
- start while busy is ignored; the base and buffer are unaffected.
- Outputs are registered.
  - mem_addr/mem_wdata hold their last values when idle and are don't-care when mem_we=0.
  - The bench checks them only with mem_we=1.
- Address arithmetic is modulo 2^addrwidth: base near the top wraps to 0 with no error.
- vec_in changing after the WAIT capture has no effect on the transfer.
- Timing with mem_ready held high and start at cycle T:
  - busy=1 at T+1.
  - First write accepted at T+2; last write at T+matsize+1.
  - done=1 at T+matsize+2, busy=0 at T+matsize+3.
  - Minimum start-to-start spacing is matsize+3 cycles.

Test Plan:
1. Basic transfer:
   - Stimulus: matsize=16, PE results c[i]=i+100 valid at T+1, base=0x0040, start at T, mem_ready=1.
   - Required: writes addr 0x0040..0x004F, data 100..115, one per cycle from T+2; done only at T+18.
2. Backpressure:
   - Stimulus: mem_ready low on alternate cycles.
   - Required: every word written exactly once, in order; addr/data stable while stalled; done after 16 accepts.
3. Address wrap:
   - Stimulus: addrwidth=16, base=0xFFFE.
   - Required: addresses FFFE, FFFF, 0000 ... 000D.
4. Capture timing:
   - Stimulus: vec_in changes to all 0xDEADBEEF at T+2.
   - Required: streamed data equals the T+1 values.
5. Start while busy:
   - Stimulus: start pulses at T+5 and at the done cycle.
   - Required: ignored; single transfer, single done pulse; a later start in IDLE is accepted.
6. Reset mid-operation:
   - Stimulus: RESET low at the 5th write.
   - Required: mem_we/busy/done=0 immediately (async); after release, IDLE, no further writes until a new start.
